bus_arbiter_split: RTL and testbench

//  Two-master bus arbiter with SPLIT/RETRY support; sits directly upstream of the bus data_path
//  and produces grant_1/grant_2, master-select and phase strobes steering its address/data muxes.

---
 rtl/bus_arbiter_split_if.sv | 26 ++
 rtl/bus_arbiter_split.sv | 98 +++++++++
 tb/tb_bus_arbiter_split.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_split_if.sv
// Bus-side signal bundle between the split-capable arbiter and its masters/slaves/data_path.
// The master modport is the arbiter's view; slave is the surrounding bus fabric.
interface bus_arbiter_split_if;
    logic       busreq_1;
    logic       busreq_2;
    logic       slave_rdy;
    logic [1:0] slave_resp;
    logic [1:0] split_done;
    logic       grant_1;
    logic       grant_2;
    logic       msel;
    logic       addr_phase;
    logic       data_phase;
    logic [1:0] split_mask;
    logic       error;

    modport master (
        input  busreq_1, busreq_2, slave_rdy, slave_resp, split_done,
        output grant_1, grant_2, msel, addr_phase, data_phase, split_mask, error
    );

    modport slave (
        output busreq_1, busreq_2, slave_rdy, slave_resp, split_done,
        input  grant_1, grant_2, msel, addr_phase, data_phase, split_mask, error
    );
endinterface

// File: rtl/bus_arbiter_split.sv
// Two-master round-robin bus arbiter with SPLIT/RETRY handling and DATA-phase timeout.
// All outputs are registered; msel doubles as the current owner (0 = master 1, 1 = master 2).
module bus_arbiter_split #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_arbiter_split_if.master  bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [1:0]       RESP_ERROR = 2'b01;
    localparam logic [1:0]       RESP_RETRY = 2'b10;
    localparam logic [1:0]       RESP_SPLIT = 2'b11;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic             last_owner;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       eff_req;
    logic             pick;
    logic [1:0]       split_set;

    assign eff_req = {bus.busreq_2, bus.busreq_1} & ~bus.split_mask;

    // On a tie the master that did not own the bus last wins
    always_comb begin
        pick = eff_req[1];
        if (eff_req == 2'b11)
            pick = ~last_owner;
    end

    always_comb begin
        split_set = 2'b00;
        if (state == DATA && bus.slave_rdy && bus.slave_resp == RESP_SPLIT)
            split_set[bus.msel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            last_owner     <= 1'b1;
            wait_cnt       <= '0;
            bus.grant_1    <= 1'b0;
            bus.grant_2    <= 1'b0;
            bus.msel       <= 1'b0;
            bus.addr_phase <= 1'b0;
            bus.data_phase <= 1'b0;
            bus.split_mask <= 2'b00;
            bus.error      <= 1'b0;
        end else begin
            bus.error <= 1'b0;
            // A SPLIT landing in the same cycle as its release keeps the master parked
            bus.split_mask <= (bus.split_mask & ~bus.split_done) | split_set;
            case (state)
                IDLE: begin
                    if (|eff_req) begin
                        state          <= ADDR;
                        bus.grant_1    <= ~pick;
                        bus.grant_2    <= pick;
                        bus.msel       <= pick;
                        bus.addr_phase <= 1'b1;
                    end
                end
                ADDR: begin
                    state          <= DATA;
                    bus.addr_phase <= 1'b0;
                    bus.data_phase <= 1'b1;
                    wait_cnt       <= '0;
                end
                DATA: begin
                    if (bus.slave_rdy) begin
                        state          <= IDLE;
                        bus.grant_1    <= 1'b0;
                        bus.grant_2    <= 1'b0;
                        bus.data_phase <= 1'b0;
                        // RETRY leaves priority untouched so the retrying master wins the next tie
                        if (bus.slave_resp != RESP_RETRY)
                            last_owner <= bus.msel;
                        if (bus.slave_resp == RESP_ERROR)
                            bus.error <= 1'b1;
                    end else if (wait_cnt == CNT_LAST) begin
                        state          <= IDLE;
                        bus.grant_1    <= 1'b0;
                        bus.grant_2    <= 1'b0;
                        bus.data_phase <= 1'b0;
                        bus.error      <= 1'b1;
                        last_owner     <= bus.msel;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter_split.sv
// Scoreboard bench for bus_arbiter_split: stimulus queues expected grants and transfer endings,
// a negedge monitor pops and compares them whenever a grant rises or falls.
module tb_bus_arbiter_split;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    bit   started = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter_split_if bus ();

    bus_arbiter_split #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       err;
        logic [1:0] mask;
        int         dlen;   // -1: transfer cut short by reset, lengths not checked
    } end_t;

    int   exp_grant_q[$];
    end_t exp_end_q[$];
    int   nvec  = 0;
    int   nfail = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_grant_1"},    bus.grant_1,    0);
        check({tag, "_grant_2"},    bus.grant_2,    0);
        check({tag, "_msel"},       bus.msel,       0);
        check({tag, "_addr_phase"}, bus.addr_phase, 0);
        check({tag, "_data_phase"}, bus.data_phase, 0);
        check({tag, "_error"},      bus.error,      0);
        check({tag, "_split_mask"}, bus.split_mask, 0);
    endtask

    // Monitor: grant rise -> compare owner; grant fall -> compare error/mask/lengths
    bit   prev_g = 1'b0;
    int   gcnt   = 0;
    int   dcnt   = 0;
    always @(negedge clk) begin
        int   em;
        end_t ee;
        bit   g;
        if (started) begin
            g = bus.grant_1 | bus.grant_2;
            check("grant_exclusive", bus.grant_1 & bus.grant_2, 0);
            if (g && !prev_g) begin
                if (exp_grant_q.size() == 0) begin
                    check("grant_queue", exp_grant_q.size(), 1);
                end else begin
                    em = exp_grant_q.pop_front();
                    check("grant_owner", {bus.grant_2, bus.grant_1}, (em == 1) ? 2'b01 : 2'b10);
                    check("grant_msel", bus.msel, (em == 2) ? 1 : 0);
                    check("grant_addr_phase", bus.addr_phase, 1);
                end
                gcnt = 0;
                dcnt = 0;
            end
            if (g) gcnt++;
            if (bus.data_phase === 1'b1) dcnt++;
            if (!g && prev_g) begin
                if (exp_end_q.size() == 0) begin
                    check("end_queue", exp_end_q.size(), 1);
                end else begin
                    ee = exp_end_q.pop_front();
                    check("end_error", bus.error, ee.err);
                    check("end_split_mask", bus.split_mask, ee.mask);
                    if (ee.dlen >= 0) begin
                        check("data_len", dcnt, ee.dlen);
                        check("grant_len", gcnt, ee.dlen + 1);
                    end
                end
            end else if (bus.error !== 1'b0) begin
                check("stray_error", bus.error, 0);
            end
            prev_g = g;
        end
    end

    task automatic wait_data();
        int k = 0;
        while (bus.data_phase !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (bus.data_phase !== 1'b1) check("data_phase_wait", bus.data_phase, 1);
    endtask

    // n > 0: slave answers on the n-th DATA cycle; n == 0: slave never answers (timeout)
    task automatic do_xfer(int m, int n, logic [1:0] resp, logic err, logic [1:0] mask,
                           logic [1:0] sd = 2'b00);
        end_t e;
        int   k = 0;
        e.err  = err;
        e.mask = mask;
        e.dlen = (n == 0) ? TIMEOUT : n;
        exp_grant_q.push_back(m);
        exp_end_q.push_back(e);
        wait_data();
        if (n > 0) begin
            repeat (n - 1) @(negedge clk);
            bus.slave_rdy  = 1'b1;
            bus.slave_resp = resp;
            bus.split_done = sd;
            @(negedge clk);
            bus.slave_rdy  = 1'b0;
            bus.slave_resp = 2'b00;
            bus.split_done = 2'b00;
        end else begin
            while ((bus.grant_1 | bus.grant_2) && k < 40) begin
                @(negedge clk);
                k++;
            end
            if (bus.grant_1 | bus.grant_2) check("timeout_grant_drop", bus.grant_1 | bus.grant_2, 0);
        end
    endtask

    initial begin
        end_t e;
        bus.busreq_1   = 1'b0;
        bus.busreq_2   = 1'b0;
        bus.slave_rdy  = 1'b0;
        bus.slave_resp = 2'b00;
        bus.split_done = 2'b00;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        started = 1'b1;

        // Single request, OKAY on 2nd DATA cycle: grant_1 for 3 cycles
        bus.busreq_1 = 1'b1;
        do_xfer(1, 2, 2'b00, 1'b0, 2'b00);
        bus.busreq_1 = 1'b0;
        @(negedge clk);

        // Both requesting: strict alternation (last owner was master 1)
        bus.busreq_1 = 1'b1;
        bus.busreq_2 = 1'b1;
        do_xfer(2, 1, 2'b00, 1'b0, 2'b00);
        do_xfer(1, 3, 2'b00, 1'b0, 2'b00);
        do_xfer(2, 2, 2'b00, 1'b0, 2'b00);
        do_xfer(1, 1, 2'b00, 1'b0, 2'b00);
        bus.busreq_1 = 1'b0;
        bus.busreq_2 = 1'b0;
        @(negedge clk);

        // ERROR response from master 2's slave
        bus.busreq_2 = 1'b1;
        do_xfer(2, 2, 2'b01, 1'b1, 2'b00);
        bus.busreq_2 = 1'b0;
        @(negedge clk);

        // SPLIT on master 1 with a simultaneous release: set wins, master 2 served next
        bus.busreq_1 = 1'b1;
        bus.busreq_2 = 1'b1;
        do_xfer(1, 1, 2'b11, 1'b0, 2'b01, 2'b01);
        do_xfer(2, 1, 2'b00, 1'b0, 2'b01);
        bus.busreq_2   = 1'b0;
        bus.split_done = 2'b01;
        @(negedge clk);
        bus.split_done = 2'b00;
        check("split_release_mask", bus.split_mask, 2'b00);
        do_xfer(1, 1, 2'b00, 1'b0, 2'b00);
        bus.busreq_1 = 1'b0;
        @(negedge clk);

        // RETRY on master 2 keeps its tie priority
        bus.busreq_1 = 1'b1;
        bus.busreq_2 = 1'b1;
        do_xfer(2, 1, 2'b10, 1'b0, 2'b00);
        do_xfer(2, 2, 2'b00, 1'b0, 2'b00);
        do_xfer(1, 1, 2'b00, 1'b0, 2'b00);

        // Both masters parked: no grant, stray slave_rdy ignored
        do_xfer(2, 1, 2'b11, 1'b0, 2'b10);
        do_xfer(1, 2, 2'b11, 1'b0, 2'b11);
        bus.slave_rdy  = 1'b1;
        bus.slave_resp = 2'b11;
        repeat (4) @(negedge clk);
        bus.slave_rdy  = 1'b0;
        bus.slave_resp = 2'b00;
        check("parked_grants", {bus.grant_2, bus.grant_1}, 2'b00);
        check("parked_mask", bus.split_mask, 2'b11);

        // Release master 2 only, then let its slave hang until timeout
        bus.split_done = 2'b10;
        @(negedge clk);
        bus.split_done = 2'b00;
        do_xfer(2, 0, 2'b00, 1'b1, 2'b01);

        // Master 2 again (master 1 still parked); reset in the middle of DATA
        exp_grant_q.push_back(2);
        e.err  = 1'b0;
        e.mask = 2'b00;
        e.dlen = -1;
        exp_end_q.push_back(e);
        wait_data();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        bus.busreq_1 = 1'b0;
        bus.busreq_2 = 1'b0;

        repeat (3) @(negedge clk);
        check("grant_queue_drained", exp_grant_q.size(), 0);
        check("end_queue_drained", exp_end_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
